// File: rtl/wave_cap_pkg.sv
// Shared constants, state encoding and sample helpers for the waveform capture controller.
package wave_cap_pkg;

    localparam int CAP_LEN              = 1903;
    localparam int X_START              = 9;
    localparam int Y_MAX                = 252;
    localparam int ADDR_W               = 11;
    localparam int SAMPLE_W             = 8;
    localparam int POS_W                = 12;
    localparam int DEFAULT_AUTO_TIMEOUT = 65535;

    typedef enum logic [1:0] {
        ST_ARM     = 2'd0,
        ST_CAPTURE = 2'd1,
        ST_DONE    = 2'd2
    } cap_state_e;

    function automatic logic [SAMPLE_W-1:0] clamp_sample(input logic [SAMPLE_W-1:0] v);
        clamp_sample = (v > SAMPLE_W'(Y_MAX)) ? SAMPLE_W'(Y_MAX) : v;
    endfunction

endpackage

// File: rtl/wave_capture_ctrl_if.sv
// Sample input and display column/row/data signals shared between the ADC side, the controller and video_display.
interface wave_capture_ctrl_if;
    import wave_cap_pkg::*;

    logic [SAMPLE_W-1:0] adc_data;
    logic                adc_valid;
    logic [POS_W-1:0]    pixel_xpos;
    logic [POS_W-1:0]    pixel_ypos;
    logic [SAMPLE_W-1:0] wave_data;

    modport master (
        output adc_data, adc_valid, pixel_xpos, pixel_ypos,
        input  wave_data
    );

    modport slave (
        input  adc_data, adc_valid, pixel_xpos, pixel_ypos,
        output wave_data
    );

endinterface

// File: rtl/wave_buf_ram.sv
// Ping-pong sample buffer: simple dual-port RAM, bank selected by the address MSB, registered read.
module wave_buf_ram
    import wave_cap_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                we,
    input  logic [ADDR_W:0]     waddr,
    input  logic [SAMPLE_W-1:0] wdata,
    input  logic                re,
    input  logic [ADDR_W:0]     raddr,
    output logic [SAMPLE_W-1:0] rdata
);

    logic [SAMPLE_W-1:0] mem [0:(2**(ADDR_W+1))-1];
    logic [SAMPLE_W-1:0] rdata_q;
    logic [SAMPLE_W-1:0] rdata_d;

    // Write port; contents are never cleared by reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read data, forced to zero when the column lies outside the trace.
    always_comb begin
        rdata_d = '0;
        if (re) begin
            rdata_d = mem[raddr];
        end else begin
            rdata_d = '0;
        end
    end

    // Output register with synchronous clear.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= rdata_d;
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/wave_capture_ctrl.sv
// Trigger/decimation capture FSM feeding a ping-pong buffer; banks swap only at frame start.
module wave_capture_ctrl
    import wave_cap_pkg::*;
#(
    parameter int unsigned AUTO_TIMEOUT = DEFAULT_AUTO_TIMEOUT
) (
    input  logic                pixel_clk,
    input  logic                sys_rst,
    wave_capture_ctrl_if.slave  bus,
    input  logic [7:0]          decim,
    input  logic [7:0]          trig_level,
    input  logic                trig_edge,
    input  logic                trig_auto,
    input  logic                hold,
    output logic                trig_seen,
    output logic                frame_upd,
    output logic                busy
);

    cap_state_e          state_q, state_d;
    logic                cap_bank_q, cap_bank_d;
    logic                disp_bank_q, disp_bank_d;
    logic [7:0]          dec_q, dec_d;
    logic [15:0]         tmo_q, tmo_d;
    logic [SAMPLE_W-1:0] prev_q, prev_d;
    logic                prev_valid_q, prev_valid_d;
    logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
    logic                fs_prev_q, fs_prev_d;
    logic                frame_start_q, frame_start_d;
    logic                trig_seen_q, trig_seen_d;
    logic                frame_upd_q, frame_upd_d;
    logic                busy_q, busy_d;

    logic                accept;
    logic                trig_hit;
    logic                timeout_hit;
    logic                we;
    logic                rd_in_range;
    logic [ADDR_W-1:0]   rd_off;
    logic [SAMPLE_W-1:0] ram_rdata;

    // Decimation, trigger detection, frame-start edge and read addressing.
    always_comb begin
        accept = bus.adc_valid && (dec_q == 8'd0);
        dec_d  = dec_q;
        if (!bus.adc_valid) begin
            dec_d = dec_q;
        end else if (dec_q == 8'd0) begin
            dec_d = decim;
        end else begin
            dec_d = dec_q - 8'd1;
        end

        if (trig_edge) begin
            trig_hit = prev_valid_q && (prev_q >= trig_level) && (bus.adc_data < trig_level);
        end else begin
            trig_hit = prev_valid_q && (prev_q < trig_level) && (bus.adc_data >= trig_level);
        end
        timeout_hit = trig_auto && (tmo_q == 16'(AUTO_TIMEOUT - 1));

        fs_prev_d     = (bus.pixel_xpos == 12'd0) && (bus.pixel_ypos == 12'd0);
        frame_start_d = fs_prev_d && !fs_prev_q;

        rd_in_range = (bus.pixel_xpos >= POS_W'(X_START)) &&
                      (bus.pixel_xpos <  POS_W'(X_START + CAP_LEN));
        rd_off      = ADDR_W'(bus.pixel_xpos - POS_W'(X_START));
    end

    // Capture FSM; wr_addr is held at 0 whenever the block is outside CAPTURE.
    always_comb begin
        state_d      = state_q;
        cap_bank_d   = cap_bank_q;
        disp_bank_d  = disp_bank_q;
        tmo_d        = tmo_q;
        wr_addr_d    = wr_addr_q;
        prev_d       = prev_q;
        prev_valid_d = prev_valid_q;
        trig_seen_d  = 1'b0;
        frame_upd_d  = 1'b0;
        we           = 1'b0;

        if (accept) begin
            prev_d       = bus.adc_data;
            prev_valid_d = 1'b1;
        end else begin
            prev_d       = prev_q;
        end

        case (state_q)
            ST_ARM: begin
                if (accept && (trig_hit || timeout_hit)) begin
                    we          = 1'b1;
                    wr_addr_d   = wr_addr_q + ADDR_W'(1);
                    tmo_d       = 16'd0;
                    trig_seen_d = trig_hit;
                    state_d     = ST_CAPTURE;
                end else if (accept && trig_auto) begin
                    tmo_d = tmo_q + 16'd1;
                end else begin
                    tmo_d = tmo_q;
                end
            end
            ST_CAPTURE: begin
                if (accept) begin
                    we = 1'b1;
                    if (wr_addr_q == ADDR_W'(CAP_LEN - 1)) begin
                        wr_addr_d = '0;
                        state_d   = ST_DONE;
                    end else begin
                        wr_addr_d = wr_addr_q + ADDR_W'(1);
                    end
                end else begin
                    wr_addr_d = wr_addr_q;
                end
            end
            ST_DONE: begin
                if (frame_start_q && !hold) begin
                    cap_bank_d   = disp_bank_q;
                    disp_bank_d  = cap_bank_q;
                    frame_upd_d  = 1'b1;
                    prev_valid_d = 1'b0;
                    state_d      = ST_ARM;
                end else begin
                    state_d = ST_DONE;
                end
            end
            default: begin
                wr_addr_d = '0;
                state_d   = ST_ARM;
            end
        endcase

        busy_d = (state_d == ST_CAPTURE);
    end

    // State and output registers.
    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            state_q       <= ST_ARM;
            cap_bank_q    <= 1'b0;
            disp_bank_q   <= 1'b1;
            dec_q         <= 8'd0;
            tmo_q         <= 16'd0;
            prev_q        <= '0;
            prev_valid_q  <= 1'b0;
            wr_addr_q     <= '0;
            fs_prev_q     <= 1'b0;
            frame_start_q <= 1'b0;
            trig_seen_q   <= 1'b0;
            frame_upd_q   <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            cap_bank_q    <= cap_bank_d;
            disp_bank_q   <= disp_bank_d;
            dec_q         <= dec_d;
            tmo_q         <= tmo_d;
            prev_q        <= prev_d;
            prev_valid_q  <= prev_valid_d;
            wr_addr_q     <= wr_addr_d;
            fs_prev_q     <= fs_prev_d;
            frame_start_q <= frame_start_d;
            trig_seen_q   <= trig_seen_d;
            frame_upd_q   <= frame_upd_d;
            busy_q        <= busy_d;
        end
    end

    // Samples are clamped on the way in so the RAM output register is the only read stage.
    wave_buf_ram u_ram (
        .clk   (pixel_clk),
        .rst   (sys_rst),
        .we    (we),
        .waddr ({cap_bank_q, wr_addr_q}),
        .wdata (clamp_sample(bus.adc_data)),
        .re    (rd_in_range),
        .raddr ({disp_bank_q, rd_off}),
        .rdata (ram_rdata)
    );

    assign bus.wave_data = ram_rdata;
    assign trig_seen     = trig_seen_q;
    assign frame_upd     = frame_upd_q;
    assign busy          = busy_q;

endmodule

// File: tb/tb_wave_capture_ctrl.sv
// Directed bench for wave_capture_ctrl: triggers, decimation, auto timeout, hold, clamp/bounds and reset.
module tb_wave_capture_ctrl;

    logic       clk = 1'b0;
    logic       sys_rst;
    logic [7:0] decim;
    logic [7:0] trig_level;
    logic       trig_edge;
    logic       trig_auto;
    logic       hold;
    logic       trig_seen;
    logic       frame_upd;
    logic       busy;
    int         n_vec  = 0;
    int         n_miss = 0;
    int         early  = 0;

    always #5 clk = ~clk;

    wave_capture_ctrl_if bus();

    wave_capture_ctrl #(.AUTO_TIMEOUT(16)) dut (
        .pixel_clk  (clk),
        .sys_rst    (sys_rst),
        .bus        (bus),
        .decim      (decim),
        .trig_level (trig_level),
        .trig_edge  (trig_edge),
        .trig_auto  (trig_auto),
        .hold       (hold),
        .trig_seen  (trig_seen),
        .frame_upd  (frame_upd),
        .busy       (busy)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] v);
        bus.adc_data  = v;
        bus.adc_valid = 1'b1;
        step();
        bus.adc_valid = 1'b0;
    endtask

    task automatic frame();
        bus.pixel_xpos = 12'd0;
        bus.pixel_ypos = 12'd0;
        step();
        bus.pixel_xpos = 12'd2000;
        bus.pixel_ypos = 12'd5;
        step();
    endtask

    task automatic rd(input string tag, input logic [11:0] x, input logic [7:0] exp);
        bus.pixel_xpos = x;
        step();
        chk(tag, 32'(bus.wave_data), 32'(exp));
    endtask

    initial begin
        sys_rst        = 1'b1;
        decim          = 8'd0;
        trig_level     = 8'd128;
        trig_edge      = 1'b0;
        trig_auto      = 1'b0;
        hold           = 1'b0;
        bus.adc_data   = 8'd0;
        bus.adc_valid  = 1'b0;
        bus.pixel_xpos = 12'd2000;
        bus.pixel_ypos = 12'd5;
        step();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_trig_seen", 32'(trig_seen), 32'd0);
        chk("rst_frame_upd", 32'(frame_upd), 32'd0);
        chk("rst_wave_data", 32'(bus.wave_data), 32'd0);
        step();
        sys_rst = 1'b0;

        // Rising trigger on a ramp from 100
        for (int i = 0; i < 28; i++) begin
            send(8'(100 + i));
            if (trig_seen) early++;
        end
        chk("t1_no_early_trig", 32'(early), 32'd0);
        send(8'd128);
        chk("t1_trig_seen", 32'(trig_seen), 32'd1);
        chk("t1_busy", 32'(busy), 32'd1);
        send(8'd129);
        chk("t1_trig_pulse_end", 32'(trig_seen), 32'd0);
        for (int j = 2; j <= 100; j++) send(8'(128 + j));
        frame();
        chk("t1_no_swap_capture", 32'(frame_upd), 32'd0);
        for (int j = 101; j <= 1901; j++) send(8'(128 + j));
        chk("t1_busy_before_last", 32'(busy), 32'd1);
        send(8'(128 + 1902));
        chk("t1_busy_after_last", 32'(busy), 32'd0);
        frame();
        chk("t1_frame_upd", 32'(frame_upd), 32'd1);
        step();
        chk("t1_frame_upd_pulse", 32'(frame_upd), 32'd0);
        rd("t1_x9", 12'd9, 8'd128);
        rd("t1_x10", 12'd10, 8'd129);
        rd("t1_x8_zero", 12'd8, 8'd0);
        rd("t1_x1912_zero", 12'd1912, 8'd0);
        rd("t1_x132", 12'd132, 8'd251);
        rd("t1_clamp255", 12'd136, 8'd252);
        rd("t1_x1911", 12'd1911, 8'd238);
        rd("lat_setup", 12'd9, 8'd128);
        bus.pixel_xpos = 12'd10;
        #1;
        chk("lat_no_early", 32'(bus.wave_data), 32'd128);
        step();
        chk("lat_one_cycle", 32'(bus.wave_data), 32'd129);

        // Falling trigger with decimation by 4
        decim     = 8'd3;
        trig_edge = 1'b1;
        for (int k = 0; k <= 7684; k++) begin
            send(8'(200 - k));
            if (k == 75) chk("t2_no_early_trig", 32'(trig_seen), 32'd0);
            if (k == 76) chk("t2_trig_seen", 32'(trig_seen), 32'd1);
            if (k == 7683) chk("t2_busy_before_last", 32'(busy), 32'd1);
        end
        chk("t2_busy_after_last", 32'(busy), 32'd0);
        frame();
        chk("t2_frame_upd", 32'(frame_upd), 32'd1);
        rd("t2_addr0", 12'd9, 8'd124);
        rd("t2_addr1", 12'd10, 8'd120);
        rd("t2_addr2", 12'd11, 8'd116);
        rd("t2_addr3", 12'd12, 8'd112);

        // Auto timeout on a flat input; three strobes drain the decimation counter first
        decim     = 8'd0;
        trig_edge = 1'b0;
        trig_auto = 1'b1;
        for (int i = 0; i < 3; i++) send(8'd50);
        for (int i = 1; i <= 15; i++) send(8'd50);
        chk("t3_busy_15", 32'(busy), 32'd0);
        send(8'd50);
        chk("t3_busy_16", 32'(busy), 32'd1);
        chk("t3_no_trig_seen", 32'(trig_seen), 32'd0);
        for (int i = 0; i < 1902; i++) send(8'd50);
        chk("t3_done", 32'(busy), 32'd0);
        frame();
        chk("t3_frame_upd", 32'(frame_upd), 32'd1);
        rd("t3_x9", 12'd9, 8'd50);
        rd("t3_x1000", 12'd1000, 8'd50);
        rd("t3_x1911", 12'd1911, 8'd50);

        // Hold freezes the display while capture completes; trigger sample 255 is clamped
        trig_auto = 1'b0;
        hold      = 1'b1;
        send(8'd10);
        send(8'd255);
        chk("t4_trig_seen", 32'(trig_seen), 32'd1);
        for (int i = 0; i < 1902; i++) send(8'd77);
        chk("t4_done", 32'(busy), 32'd0);
        for (int f = 0; f < 3; f++) begin
            frame();
            chk("t4_hold_no_swap", 32'(frame_upd), 32'd0);
        end
        rd("t4_old_trace", 12'd9, 8'd50);
        hold = 1'b0;
        frame();
        chk("t4_release_swap", 32'(frame_upd), 32'd1);
        rd("t4_clamp", 12'd9, 8'd252);
        rd("t4_x10", 12'd10, 8'd77);

        // Reset mid-capture, then a fresh capture restarting at address 0
        send(8'd10);
        send(8'd200);
        chk("t6_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 50; i++) send(8'd60);
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
        chk("t6_rst_busy", 32'(busy), 32'd0);
        chk("t6_rst_frame_upd", 32'(frame_upd), 32'd0);
        chk("t6_rst_wave_data", 32'(bus.wave_data), 32'd0);
        frame();
        chk("t6_no_swap_arm", 32'(frame_upd), 32'd0);
        rd("t6_stale_x9", 12'd9, 8'd252);
        rd("t6_stale_x10", 12'd10, 8'd77);
        send(8'd10);
        send(8'd130);
        chk("t6_retrig", 32'(trig_seen), 32'd1);
        for (int i = 0; i < 1902; i++) send(8'd90);
        chk("t6_done", 32'(busy), 32'd0);
        frame();
        chk("t6_frame_upd", 32'(frame_upd), 32'd1);
        rd("t6_addr0", 12'd9, 8'd130);
        rd("t6_addr2", 12'd11, 8'd90);
        rd("t6_addr51", 12'd60, 8'd90);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/wave_capture_ctrl.md
Name: wave_capture_ctrl

Overview:
- Captures the 8-bit sampled waveform into a ping-pong sample buffer on a level/edge trigger, with decimation and an auto-trigger timeout.
- Serves one sample per displayed column to video_display's datain, indexed by pixel_xpos.
- Swaps display and capture banks only at frame start, so a frame never shows a partially written trace.
- Sits between the ADC sample interface and video_display, all in the pixel_clk domain.

Parameters:
- CAP_LEN, 1903: samples per trace; equals the number of displayed columns, x = 9..1911.
- X_START, 9: first pixel_xpos column that shows sample 0.
- Y_MAX, 252: output clamp; the plot spans rows 232..484.
- AUTO_TIMEOUT, 65535: accepted samples in ARM with no trigger before a forced capture (auto mode).
- ADDR_W, 11: buffer address width; 2^ADDR_W must be >= CAP_LEN.

Ports:
- pixel_clk  in  1  clock, same as video_display.
- sys_rst  in  1  synchronous reset, active-high.
- adc_data  in  8  sample value, unsigned.
- adc_valid  in  1  one-cycle sample strobe.
- decim  in  8  keep 1 of every decim+1 valid samples; 0 means keep all.
- trig_level  in  8  trigger threshold.
- trig_edge  in  1  0 = rising, 1 = falling.
- trig_auto  in  1  1 = auto mode, 0 = normal mode.
- hold  in  1  1 = freeze the displayed trace (no bank swaps).
- pixel_xpos  in  12  current column.
- pixel_ypos  in  12  current row.
- wave_data  out  8  sample for the column, to video_display datain.
- trig_seen  out  1  one-cycle pulse when a capture starts on a real trigger.
- frame_upd  out  1  one-cycle pulse when the banks swap.
- busy  out  1  high while in CAPTURE.

Behaviour:
- Reset values: state = ARM, cap_bank = 0, disp_bank = 1, decimation counter = 0, timeout counter = 0, prev_valid = 0, wave_data = 0, trig_seen = 0, frame_upd = 0, busy = 0.
- Accepted sample: adc_valid = 1 and decimation counter == 0. The counter then reloads with decim; on other valid strobes it decrements. No counting without adc_valid.
- prev_sample and prev_valid update on every accepted sample.

State ARM:
- Rising edge trigger: prev_valid and prev < trig_level and cur >= trig_level.
- Falling edge trigger: prev_valid and prev >= trig_level and cur < trig_level.
- On trigger: write cur at address 0, go to CAPTURE with wr_addr = 1, pulse trig_seen.
- Auto mode, no trigger: timeout counter increments per accepted sample. When it reaches AUTO_TIMEOUT, capture cur the same way, but without trig_seen.
- Timeout counter clears when leaving ARM.

State CAPTURE:
- Each accepted sample writes to cap_bank[wr_addr], then wr_addr increments.
- The write at wr_addr == CAP_LEN-1 moves the block to DONE. busy = 1 only in CAPTURE.

State DONE:
- Waits for the frame-start pulse: a registered rising detect of (pixel_xpos == 0 && pixel_ypos == 0).
- At frame start with hold = 0: swap cap_bank and disp_bank, pulse frame_upd, go to ARM with prev_valid = 0.
- At frame start with hold = 1: stay in DONE.
- Samples arriving in DONE are discarded.

Read side:
- When X_START <= pixel_xpos < X_START+CAP_LEN, read disp_bank[pixel_xpos - X_START]; otherwise the output is 0.
- wave_data = min(read value, Y_MAX), registered. Latency is 1 pixel_clk from pixel_xpos to wave_data.
- Subtraction uses 12 bits; address = low ADDR_W bits.

Other rules:
- A swap coinciding with a read takes effect on the next cycle's read. The output never mixes banks within one frame.
- Frame start in ARM or CAPTURE: no swap. The old trace stays displayed.
- hold affects only the swap; capture into cap_bank still completes.
- Reset mid-capture abandons the partial trace. Both banks keep their stale RAM contents; RAM contents are not cleared.

Decomposition:
- Package wave_cap_pkg: state encoding (ARM, CAPTURE, DONE), CAP_LEN, X_START, Y_MAX, ADDR_W.
- One sub-module, wave_buf_ram: simple dual-port RAM, 2*2^ADDR_W x 8, bank = address MSB, registered read, one write port and one read port.

Test Plan:
- Rising trigger: decim = 0, trig_level = 128, trig_auto = 0, adc ramp 100..160 step 1 -> trig_seen pulses on the sample 128; the following 1902 samples fill the bank; busy falls after the last write; frame_upd at the next frame start; column x = 9 reads 128, x = 10 reads 129.
- Falling trigger, with decim = 3 -> capture starts on the first accepted sample < level that follows one >= level; only every 4th valid strobe is written (verify addresses 0..3 hold samples n, n+4, n+8, n+12).
- Auto timeout: trig_auto = 1, AUTO_TIMEOUT = 16, constant input 50 -> capture starts on the 16th accepted sample with no trig_seen; the displayed trace is all 50.
- hold = 1 after capture completes -> no frame_upd for 3 frames; wave_data still shows the old trace. Release hold -> swap at the next frame start.
- Clamp and bounds: stored sample 255 -> wave_data = 252. Reads at x = 8 and x = 1912 -> wave_data = 0. Exact 1-cycle latency checked.
- sys_rst asserted mid-CAPTURE -> busy = 0, state ARM, no frame_upd. A new trigger restarts writing at address 0.
